// File: rtl/lc3b_ctrl_pkg.sv
// rtl/lc3b_ctrl_pkg.sv - shared states, opcodes, aluop codes and control word for the LC-3b controller
package lc3b_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH1 = 4'd0,
        ST_FETCH2 = 4'd1,
        ST_FETCH3 = 4'd2,
        ST_DECODE = 4'd3,
        ST_ALU    = 4'd4,
        ST_LDW1   = 4'd5,
        ST_LDW2   = 4'd6,
        ST_LDW3   = 4'd7,
        ST_STW1   = 4'd8,
        ST_STW2   = 4'd9,
        ST_HALT   = 4'd10,
        ST_ERROR  = 4'd11
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDW  = 4'b0110;
    localparam logic [3:0] OP_STW  = 4'b0111;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_AND = 3'b001;
    localparam logic [2:0] ALUOP_NOT = 3'b010;

    typedef struct packed {
        logic [2:0] aluop;
        logic       ldcc;
        logic       ldir;
        logic       ldreg;
        logic       ldpc;
        logic       ldmar;
        logic       ldmdr;
        logic       memen;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic       halted;
        logic       error;
    } ctrl_t;

    function automatic logic [2:0] alu_sel(input logic [3:0] opcode);
        case (opcode)
            OP_AND:  alu_sel = ALUOP_AND;
            OP_NOT:  alu_sel = ALUOP_NOT;
            default: alu_sel = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/lc3b_ctrl_decode.sv
// rtl/lc3b_ctrl_decode.sv - combinational state-to-control-word decode
module lc3b_ctrl_decode
    import lc3b_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [3:0] opcode_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH1: begin
                ctrl_o.gate_pc = 1'b1;
                ctrl_o.ldmar   = 1'b1;
                ctrl_o.ldpc    = 1'b1;
            end
            ST_FETCH2: ctrl_o.ldmdr = 1'b1;
            ST_FETCH3: ctrl_o.ldir  = 1'b1;
            ST_ALU: begin
                ctrl_o.gate_alu = 1'b1;
                ctrl_o.ldreg    = 1'b1;
                ctrl_o.ldcc     = 1'b1;
                ctrl_o.aluop    = alu_sel(opcode_i);
            end
            ST_LDW1, ST_STW1: begin
                ctrl_o.gate_marmux = 1'b1;
                ctrl_o.ldmar       = 1'b1;
            end
            ST_LDW2: ctrl_o.ldmdr = 1'b1;
            ST_LDW3: begin
                ctrl_o.gate_mdr = 1'b1;
                ctrl_o.ldreg    = 1'b1;
            end
            ST_STW2:  ctrl_o.memen  = 1'b1;
            ST_HALT:  ctrl_o.halted = 1'b1;
            ST_ERROR: ctrl_o.error  = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/lc3b_control.sv
// rtl/lc3b_control.sv - LC-3b Moore control FSM with memory-wait timeout
module lc3b_control
    import lc3b_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        P,
    input  logic        Z,
    input  logic        R,
    output logic [2:0]  aluop,
    output logic        LDCC,
    output logic        LDIR,
    output logic        LDREG,
    output logic        LDPC,
    output logic        LDMAR,
    output logic        LDMDR,
    output logic        MEMEN,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic        halted,
    output logic        error,
    output logic [3:0]  state
);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       in_wait;
    logic       timeout;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       unused_ok;

    // Condition codes and operand fields are not consumed by this revision.
    assign unused_ok = ^{N, P, Z, IR[11:0]};

    assign in_wait = (state_q == ST_FETCH2) || (state_q == ST_LDW2) || (state_q == ST_STW2);
    assign timeout = in_wait && !R && (wait_cnt_q == 4'hF);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: if (R) state_d = ST_FETCH3;
            ST_FETCH3: state_d = ST_DECODE;
            ST_DECODE: begin
                case (IR[15:12])
                    OP_ADD, OP_AND, OP_NOT: state_d = ST_ALU;
                    OP_LDW:                 state_d = ST_LDW1;
                    OP_STW:                 state_d = ST_STW1;
                    OP_TRAP:                state_d = ST_HALT;
                    default:                state_d = ST_FETCH1;
                endcase
            end
            ST_ALU:    state_d = ST_FETCH1;
            ST_LDW1:   state_d = ST_LDW2;
            ST_LDW2:   if (R) state_d = ST_LDW3;
            ST_LDW3:   state_d = ST_FETCH1;
            ST_STW1:   state_d = ST_STW2;
            ST_STW2:   if (R) state_d = ST_FETCH1;
            default:   state_d = state_q;
        endcase
        if (timeout) begin
            state_d = ST_ERROR;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_wait && !R) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FETCH1;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    lc3b_ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (IR[15:12]),
        .ctrl_o   (ctrl)
    );

    // Reset overrides the decode so nothing reaches the datapath mid-reset.
    assign ctrl_out   = reset ? '0 : ctrl;

    assign aluop      = ctrl_out.aluop;
    assign LDCC       = ctrl_out.ldcc;
    assign LDIR       = ctrl_out.ldir;
    assign LDREG      = ctrl_out.ldreg;
    assign LDPC       = ctrl_out.ldpc;
    assign LDMAR      = ctrl_out.ldmar;
    assign LDMDR      = ctrl_out.ldmdr;
    assign MEMEN      = ctrl_out.memen;
    assign GatePC     = ctrl_out.gate_pc;
    assign GateMDR    = ctrl_out.gate_mdr;
    assign GateALU    = ctrl_out.gate_alu;
    assign GateMARMUX = ctrl_out.gate_marmux;
    assign halted     = ctrl_out.halted;
    assign error      = ctrl_out.error;
    assign state      = state_q;

endmodule

// File: doc/lc3b_control.md
LC3B_CONTROL -- requirements
Module: lc3b_control

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have the port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have the port `IR`, input, 16 bits: current instruction from the datapath instruction register.
REQ-004 SHALL have the ports `N`, `P`, `Z`, input, 1 bit each: condition codes; decoded into no action in this revision.
REQ-005 SHALL have the port `R`, input, 1 bit: memory ready; memory access completes in a cycle where R=1.
REQ-006 SHALL have the port `aluop`, output, 3 bits: ALU operation select.
REQ-007 SHALL have the ports `LDCC`, `LDIR`, `LDREG`, `LDPC`, `LDMAR`, `LDMDR`, output, 1 bit each: datapath load enables.
REQ-008 SHALL have the port `MEMEN`, output, 1 bit: memory write enable.
REQ-009 SHALL have the ports `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX`, output, 1 bit each: bus drive enables.
REQ-010 SHALL have the ports `halted` and `error`, output, 1 bit each: sticky status flags.
REQ-011 SHALL have the port `state`, output, 4 bits: current state encoding, for debug.

Function
REQ-012 SHALL implement a Moore FSM whose control outputs are decoded from the current state only; any output not listed for a state is 0.
REQ-013 SHALL implement these states and outputs:
- FETCH1: GatePC, LDMAR, LDPC.
- FETCH2: LDMDR.
- FETCH3: LDIR.
- DECODE: no outputs.
- ALU: GateALU, LDREG, LDCC, aluop per REQ-016.
- LDW1: GateMARMUX, LDMAR.
- LDW2: LDMDR.
- LDW3: GateMDR, LDREG.
- STW1: GateMARMUX, LDMAR.
- STW2: MEMEN.
- HALT: halted=1.
- ERROR: error=1.
REQ-014 SHALL follow these transitions:
- FETCH1 -> FETCH2.
- FETCH2 -> FETCH3 when R=1, else stay.
- FETCH3 -> DECODE.
- DECODE -> by IR[15:12] per REQ-015.
- ALU -> FETCH1.
- LDW1 -> LDW2.
- LDW2 -> LDW3 when R=1, else stay.
- LDW3 -> FETCH1.
- STW1 -> STW2.
- STW2 -> FETCH1 when R=1, else stay.
- HALT and ERROR are terminal until reset.
REQ-015 SHALL decode IR[15:12] in DECODE as follows:
- 0001 (ADD), 0101 (AND), 1001 (NOT) -> ALU.
- 0110 (LDW) -> LDW1.
- 0111 (STW) -> STW1.
- 1111 (TRAP) -> HALT.
- All other opcodes -> FETCH1 (executed as NOP).
REQ-016 SHALL drive aluop = 000 for ADD, 001 for AND, 010 for NOT; aluop = 000 in every state other than ALU.
REQ-017 SHALL ignore IR[5] (register-mode operands only); IR fields beyond [15:12] are not examined.
REQ-018 SHALL keep a 4-bit wait counter:
- Cleared on every state change.
- Incremented each cycle spent in FETCH2, LDW2 or STW2 with R=0.
REQ-019 SHALL enter ERROR on the edge where the counter equals 15 and R=0 in a wait state, i.e. the 16th consecutive not-ready cycle; R=1 in that same cycle takes the normal transition instead.
REQ-020 SHALL assert at most one of the four Gate outputs in any cycle.
REQ-021 SHALL never assert MEMEN in the same cycle as LDMDR or any Gate output.

Reset
REQ-022 SHALL, on a rising edge with reset=1, set state=FETCH1, clear the wait counter, and clear halted and error, including mid-access and from HALT or ERROR.
REQ-023 SHALL force every control output to 0 in any cycle where reset=1; `state` SHALL read FETCH1 from the first cycle after reset.

Structure
REQ-024 SHALL take the state encodings (FETCH1=0 ... ERROR=11), opcode constants and aluop constants from a shared package, lc3b_ctrl_pkg.
REQ-025 SHALL implement the output decode as one combinational sub-module, lc3b_ctrl_decode (state in, control word out); next-state logic and the counter SHALL reside in lc3b_control.

Verification
REQ-026 SHALL cover a fetch: release reset with R held 1 -> states FETCH1, FETCH2, FETCH3, DECODE on consecutive cycles; GatePC=LDMAR=LDPC=1 only in the first.
REQ-027 SHALL cover ADD: IR=16'h1042, R=1 -> ALU state entered 4 cycles after FETCH1 with GateALU=LDREG=LDCC=1 and aluop=000; NOT with IR=16'h927F -> aluop=010.
REQ-028 SHALL cover a delayed STW: IR=16'h7042, R held 0 for 3 cycles in STW2 -> MEMEN=1 for 4 cycles, then FETCH1.
REQ-029 SHALL cover a timeout: R held 0 in FETCH2 -> error=1 after exactly 16 cycles in FETCH2; it stays set until reset, which restores FETCH1 and error=0.
REQ-030 SHALL cover TRAP and unknown opcodes: IR=16'hF025 -> halted=1 and held with R toggling; IR=16'hD000 -> DECODE then FETCH1 with no LDREG, LDCC or MEMEN.
REQ-031 SHALL cover reset in LDW2: assert reset for 1 cycle -> all controls 0 during reset, then FETCH1 with the counter cleared; the REQ-020 and REQ-021 invariants SHALL be checked every cycle.
